// File: rtl/axis_mon_pkg.sv
// Shared constants for the AXI-Stream monitor: error vector width and bit positions.
package axis_mon_pkg;

    localparam int ERR_W        = 7;
    localparam int ERR_RSTVALID = 0;
    localparam int ERR_DROP     = 1;
    localparam int ERR_UNSTABLE = 2;
    localparam int ERR_RESERVED = 3;
    localparam int ERR_OVERLEN  = 4;
    localparam int ERR_UNDERLEN = 5;
    localparam int ERR_STALL    = 6;

    typedef logic [ERR_W-1:0] err_vec_t;

endpackage

// File: rtl/axis_mon_lenctr.sv
// Per-TDEST saturating byte-length tracker with clear-on-last and packet-size limit compares.
module axis_mon_lenctr
    import axis_mon_pkg::*;
#(
    parameter int LGPKT        = 16,
    parameter int VBW          = 3,
    parameter int F_MAX_PACKET = 0,
    parameter int F_MIN_PACKET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat,
    input  logic             last,
    input  logic [VBW-1:0]   vbytes,
    output logic [LGPKT-1:0] total,
    output logic             overlen,
    output logic             underlen
);

    localparam logic [LGPKT:0] MAXP = (LGPKT+1)'(F_MAX_PACKET);
    localparam logic [LGPKT:0] MINP = (LGPKT+1)'(F_MIN_PACKET);

    logic [LGPKT-1:0] len;
    logic [LGPKT:0]   sum;

    // One extra bit keeps the limit compares exact even when the sum overflows.
    assign sum      = {1'b0, len} + (LGPKT+1)'(vbytes);
    assign total    = sum[LGPKT] ? '1 : sum[LGPKT-1:0];
    assign overlen  = (F_MAX_PACKET != 0) && beat && (sum > MAXP);
    assign underlen = (F_MIN_PACKET != 0) && beat && last && (sum < MINP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
        end else if (beat) begin
            len <= last ? '0 : total;
        end
    end

endmodule

// File: rtl/axis_stream_monitor.sv
// Passive AXI-Stream protocol checker with per-TDEST packet length tracking and saturating statistics.
module axis_stream_monitor
    import axis_mon_pkg::*;
#(
    parameter int DW           = 32,
    parameter int IDW          = 1,
    parameter int DESTW        = 2,
    parameter int UW           = 1,
    parameter int LGPKT        = 16,
    parameter int LGCNT        = 32,
    parameter int F_MAX_PACKET = 0,
    parameter int F_MIN_PACKET = 0,
    parameter int F_MAX_STALL  = 0
) (
    input  logic              i_aclk,
    input  logic              i_aresetn,
    input  logic              i_tvalid,
    input  logic              i_tready,
    input  logic              i_tlast,
    input  logic [DW-1:0]     i_tdata,
    input  logic [DW/8-1:0]   i_tstrb,
    input  logic [DW/8-1:0]   i_tkeep,
    input  logic [IDW-1:0]    i_tid,
    input  logic [DESTW-1:0]  i_tdest,
    input  logic [UW-1:0]     i_tuser,
    input  logic              i_clear,
    output logic [ERR_W-1:0]  o_err_pulse,
    output logic [ERR_W-1:0]  o_err,
    output logic [LGCNT-1:0]  o_pkt_count,
    output logic [LGCNT-1:0]  o_beat_count,
    output logic              o_last_valid,
    output logic [LGPKT-1:0]  o_last_len,
    output logic [DESTW-1:0]  o_last_dest
);

    localparam int NB    = DW / 8;
    localparam int NCHAN = 2 ** DESTW;
    localparam int VBW   = $clog2(NB + 1);
    localparam int SW    = (F_MAX_STALL > 0) ? $clog2(F_MAX_STALL + 1) : 1;
    localparam logic [SW-1:0] STALL_LIM = SW'(F_MAX_STALL);

    logic             accept, stalled, p_stalled;
    logic [VBW-1:0]   vbytes;
    logic             data_changed, side_changed, stall_hit;
    logic [SW-1:0]    stall_cnt;
    err_vec_t         err_next;

    logic             past_valid, p_tvalid, p_tready, p_tlast;
    logic [DW-1:0]    p_tdata;
    logic [NB-1:0]    p_tstrb, p_tkeep;
    logic [IDW-1:0]   p_tid;
    logic [DESTW-1:0] p_tdest;
    logic [UW-1:0]    p_tuser;

    logic [LGPKT-1:0] chan_total [NCHAN];
    logic [NCHAN-1:0] chan_over, chan_under;

    assign accept    = i_tvalid && i_tready;
    assign stalled   = i_tvalid && !i_tready;
    assign p_stalled = past_valid && p_tvalid && !p_tready;

    always_comb begin
        vbytes = '0;
        if (i_tvalid) begin
            for (int unsigned b = 0; b < NB; b++) begin
                vbytes = vbytes + VBW'(i_tkeep[b] & i_tstrb[b]);
            end
        end
    end

    // Only bytes the current TKEEP marks as live must hold their data while stalled.
    always_comb begin
        data_changed = 1'b0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (i_tkeep[b] && (i_tdata[8*b +: 8] != p_tdata[8*b +: 8])) begin
                data_changed = 1'b1;
            end
        end
    end

    assign side_changed = (i_tstrb != p_tstrb) || (i_tkeep != p_tkeep) || (i_tlast != p_tlast)
                       || (i_tid != p_tid) || (i_tdest != p_tdest) || (i_tuser != p_tuser);

    assign stall_hit = (F_MAX_STALL != 0) && stalled && (stall_cnt == STALL_LIM - SW'(1));

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        axis_mon_lenctr #(
            .LGPKT        (LGPKT),
            .VBW          (VBW),
            .F_MAX_PACKET (F_MAX_PACKET),
            .F_MIN_PACKET (F_MIN_PACKET)
        ) u_lenctr (
            .clk      (i_aclk),
            .rst_n    (i_aresetn),
            .beat     (accept && (i_tdest == DESTW'(c))),
            .last     (i_tlast),
            .vbytes   (vbytes),
            .total    (chan_total[c]),
            .overlen  (chan_over[c]),
            .underlen (chan_under[c])
        );
    end

    always_comb begin
        err_next               = '0;
        err_next[ERR_RSTVALID] = !past_valid && i_tvalid;
        err_next[ERR_DROP]     = p_stalled && !i_tvalid;
        err_next[ERR_UNSTABLE] = p_stalled && i_tvalid && (data_changed || side_changed);
        err_next[ERR_RESERVED] = i_tvalid && |(~i_tkeep & i_tstrb);
        err_next[ERR_OVERLEN]  = chan_over[i_tdest];
        err_next[ERR_UNDERLEN] = chan_under[i_tdest];
        err_next[ERR_STALL]    = stall_hit;
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            past_valid <= 1'b0;
            p_tvalid   <= 1'b0;
            p_tready   <= 1'b0;
            p_tlast    <= 1'b0;
            p_tdata    <= '0;
            p_tstrb    <= '0;
            p_tkeep    <= '0;
            p_tid      <= '0;
            p_tdest    <= '0;
            p_tuser    <= '0;
        end else begin
            past_valid <= 1'b1;
            p_tvalid   <= i_tvalid;
            p_tready   <= i_tready;
            p_tlast    <= i_tlast;
            p_tdata    <= i_tdata;
            p_tstrb    <= i_tstrb;
            p_tkeep    <= i_tkeep;
            p_tid      <= i_tid;
            p_tdest    <= i_tdest;
            p_tuser    <= i_tuser;
        end
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            stall_cnt <= '0;
        end else if (!stalled) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_LIM) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_err_pulse  <= '0;
            o_err        <= '0;
            o_pkt_count  <= '0;
            o_beat_count <= '0;
            o_last_valid <= 1'b0;
            o_last_len   <= '0;
            o_last_dest  <= '0;
        end else begin
            o_err_pulse  <= err_next;
            o_err        <= (o_err & ~{ERR_W{i_clear}}) | err_next;
            o_last_valid <= accept && i_tlast;
            if (accept) begin
                if (o_beat_count != '1) begin
                    o_beat_count <= o_beat_count + 1'b1;
                end
                if (i_tlast) begin
                    o_last_len  <= chan_total[i_tdest];
                    o_last_dest <= i_tdest;
                    if (o_pkt_count != '1) begin
                        o_pkt_count <= o_pkt_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_stream_monitor.sv
// Bench for axis_stream_monitor: one instance with checks disabled, one with packet and stall limits.
module tb_axis_stream_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tvalid = 1'b0, tready = 1'b0, tlast = 1'b0, clear = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = '0, tkeep = '0;
    logic [0:0]  tid = '0, tuser = '0;
    logic [1:0]  tdest = '0;

    logic [6:0]  pulse_d, err_d, pulse_a, err_a;
    logic [31:0] pkt_d, beat_d, pkt_a, beat_a;
    logic        lv_d, lv_a;
    logic [15:0] llen_d, llen_a;
    logic [1:0]  ldest_d, ldest_a;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    axis_stream_monitor dut_d (
        .i_aclk(clk), .i_aresetn(rst_n), .i_tvalid(tvalid), .i_tready(tready), .i_tlast(tlast),
        .i_tdata(tdata), .i_tstrb(tstrb), .i_tkeep(tkeep), .i_tid(tid), .i_tdest(tdest),
        .i_tuser(tuser), .i_clear(clear), .o_err_pulse(pulse_d), .o_err(err_d),
        .o_pkt_count(pkt_d), .o_beat_count(beat_d), .o_last_valid(lv_d),
        .o_last_len(llen_d), .o_last_dest(ldest_d)
    );

    axis_stream_monitor #(
        .F_MAX_PACKET (8),
        .F_MIN_PACKET (2),
        .F_MAX_STALL  (4)
    ) dut_a (
        .i_aclk(clk), .i_aresetn(rst_n), .i_tvalid(tvalid), .i_tready(tready), .i_tlast(tlast),
        .i_tdata(tdata), .i_tstrb(tstrb), .i_tkeep(tkeep), .i_tid(tid), .i_tdest(tdest),
        .i_tuser(tuser), .i_clear(clear), .o_err_pulse(pulse_a), .o_err(err_a),
        .o_pkt_count(pkt_a), .o_beat_count(beat_a), .o_last_valid(lv_a),
        .o_last_len(llen_a), .o_last_dest(ldest_a)
    );

    // Reference model: previous-cycle samples, unbounded stall run length, byte totals per dest.
    typedef struct packed {
        logic            pv, pvalid, pready, plast;
        logic [31:0]     pdata;
        logic [3:0]      pkeep, pstrb;
        logic [1:0]      pdest;
        logic            pid, puser;
        int              run;
        logic [3:0][15:0] len;
        int              pkt, beat;
        logic [1:0][6:0] pulse, err;
        logic            lv;
        logic [15:0]     llen;
        logic [1:0]      ldest;
    } ms_t;

    ms_t m;

    function automatic int maxp_of(int k); return (k == 1) ? 8 : 0; endfunction
    function automatic int minp_of(int k); return (k == 1) ? 2 : 0; endfunction
    function automatic int maxs_of(int k); return (k == 1) ? 4 : 0; endfunction

    function automatic ms_t mstep(ms_t s);
        ms_t        n = s;
        int         vb = 0, tot;
        bit         acc, stl, chg;
        logic [6:0] p;
        acc = tvalid && tready;
        if (tvalid) for (int b = 0; b < 4; b++) if (tkeep[b] && tstrb[b]) vb++;
        tot = int'(s.len[tdest]) + vb;
        stl = s.pv && s.pvalid && !s.pready;
        chg = (tstrb != s.pstrb) || (tkeep != s.pkeep) || (tlast != s.plast) ||
              (tid[0] != s.pid) || (tdest != s.pdest) || (tuser[0] != s.puser);
        for (int b = 0; b < 4; b++) if (tkeep[b] && tdata[8*b +: 8] != s.pdata[8*b +: 8]) chg = 1'b1;
        n.run = (tvalid && !tready) ? s.run + 1 : 0;
        for (int k = 0; k < 2; k++) begin
            p    = '0;
            p[0] = !s.pv && tvalid;
            p[1] = stl && !tvalid;
            p[2] = stl && tvalid && chg;
            p[3] = tvalid && ((~tkeep & tstrb) != 4'h0);
            p[4] = (maxp_of(k) != 0) && acc && (tot > maxp_of(k));
            p[5] = (minp_of(k) != 0) && acc && tlast && (tot < minp_of(k));
            p[6] = (maxs_of(k) != 0) && (n.run == maxs_of(k));
            n.pulse[k] = p;
            n.err[k]   = (clear ? 7'h0 : s.err[k]) | p;
        end
        n.lv = acc && tlast;
        if (acc) begin
            n.beat = s.beat + 1;
            if (tlast) begin
                n.pkt        = s.pkt + 1;
                n.llen       = (tot > 65535) ? 16'hFFFF : 16'(tot);
                n.ldest      = tdest;
                n.len[tdest] = '0;
            end else begin
                n.len[tdest] = (tot > 65535) ? 16'hFFFF : 16'(tot);
            end
        end
        n.pv = 1'b1; n.pvalid = tvalid; n.pready = tready; n.plast = tlast;
        n.pdata = tdata; n.pkeep = tkeep; n.pstrb = tstrb; n.pdest = tdest;
        n.pid = tid[0]; n.puser = tuser[0];
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= mstep(m);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pulse_d", 64'(pulse_d), 64'(m.pulse[0]));
            chk("err_d",   64'(err_d),   64'(m.err[0]));
            chk("pulse_a", 64'(pulse_a), 64'(m.pulse[1]));
            chk("err_a",   64'(err_a),   64'(m.err[1]));
            chk("pkt_d",   64'(pkt_d),   64'(m.pkt));
            chk("beat_d",  64'(beat_d),  64'(m.beat));
            chk("pkt_a",   64'(pkt_a),   64'(m.pkt));
            chk("beat_a",  64'(beat_a),  64'(m.beat));
            chk("lv_d",    64'(lv_d),    64'(m.lv));
            chk("lv_a",    64'(lv_a),    64'(m.lv));
            chk("llen_d",  64'(llen_d),  64'(m.llen));
            chk("llen_a",  64'(llen_a),  64'(m.llen));
            chk("ldest_d", 64'(ldest_d), 64'(m.ldest));
            chk("ldest_a", 64'(ldest_a), 64'(m.ldest));
        end
    end

    task automatic step(input logic v, input logic r, input logic l, input logic [31:0] d,
                        input logic [3:0] k, input logic [3:0] s, input logic [1:0] dst);
        tvalid = v; tready = r; tlast = l; tdata = d; tkeep = k; tstrb = s; tdest = dst;
        @(negedge clk);
    endtask

    localparam logic [31:0] D = 32'h11223344;

    initial begin
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_err_d", 64'(err_d), 64'h0);
        chk("rst_pkt_d", 64'(pkt_d), 64'h0);
        rst_n = 1'b1;
        step(0, 0, 0, '0, 4'h0, 4'h0, 0);
        step(0, 0, 0, '0, 4'h0, 4'h0, 0);

        // 3-beat packet on dest 1
        step(1, 1, 0, 32'hA0A1A2A3, 4'hF, 4'hF, 1);
        step(1, 1, 0, 32'hB0B1B2B3, 4'hF, 4'hF, 1);
        chk("t1_no_over_at_8", 64'(pulse_a), 64'h0);
        step(1, 1, 1, 32'hC0C1C2C3, 4'hF, 4'hF, 1);
        chk("t1_lv",    64'(lv_d),    64'h1);
        chk("t1_len",   64'(llen_d),  64'd12);
        chk("t1_dest",  64'(ldest_d), 64'h1);
        chk("t1_pkt",   64'(pkt_d),   64'h1);
        chk("t1_err",   64'(err_d),   64'h0);
        chk("t1_err_a", 64'(err_a),   64'h10);
        step(0, 0, 0, '0, 4'h0, 4'h0, 0);
        chk("t1_lv_drop", 64'(lv_d), 64'h0);

        // stability under stall, TKEEP = 3
        step(1, 0, 0, D, 4'h3, 4'h3, 0);
        step(1, 0, 0, 32'h55663344, 4'h3, 4'h3, 0);
        chk("t2_dead_bytes", 64'(pulse_d), 64'h0);
        step(1, 0, 0, 32'h556633FF, 4'h3, 4'h3, 0);
        chk("t2_unstable", 64'(pulse_d), 64'h04);
        chk("t2_sticky",   64'(err_d),   64'h04);
        step(1, 0, 0, 32'h556633FF, 4'h3, 4'h3, 0);
        chk("t2_one_cycle", 64'(pulse_d), 64'h0);
        chk("t2_held",      64'(err_d),   64'h04);
        clear = 1'b1;
        step(1, 0, 0, 32'h556633EE, 4'h3, 4'h3, 0);
        chk("t2_set_wins", 64'(err_d), 64'h04);
        step(1, 0, 0, 32'h556633EE, 4'h3, 4'h3, 0);
        chk("t2_cleared", 64'(err_d), 64'h0);
        clear = 1'b0;
        step(1, 1, 0, 32'h556633EE, 4'h3, 4'h3, 0);
        step(1, 1, 1, D, 4'hF, 4'hF, 0);
        chk("t2_len", 64'(llen_d), 64'd6);

        // drop and reserved strobe
        step(1, 0, 0, '0, 4'hF, 4'hF, 2);
        step(0, 0, 0, '0, 4'hF, 4'hF, 2);
        chk("t3_drop", 64'(pulse_d), 64'h02);
        step(1, 1, 0, '0, 4'h0, 4'h1, 2);
        chk("t3_reserved", 64'(pulse_d), 64'h08);
        clear = 1'b1;
        step(0, 0, 0, '0, 4'h0, 4'h0, 0);
        clear = 1'b0;

        // interleaved dests against an 8-byte limit
        step(1, 1, 0, D, 4'hF, 4'hF, 0);
        chk("t4_b0", 64'(pulse_a), 64'h0);
        step(1, 1, 0, D, 4'hF, 4'hF, 1);
        chk("t4_b1", 64'(pulse_a), 64'h0);
        step(1, 1, 0, D, 4'hF, 4'hF, 0);
        chk("t4_b2", 64'(pulse_a), 64'h0);
        step(1, 1, 0, D, 4'hF, 4'hF, 0);
        chk("t4_over", 64'(pulse_a), 64'h10);
        step(1, 1, 1, D, 4'h0, 4'h0, 1);
        chk("t4_d1_len", 64'(llen_a), 64'd4);
        chk("t4_d1_dst", 64'(ldest_a), 64'd1);
        step(1, 1, 1, D, 4'h0, 4'h0, 0);
        chk("t4_d0_len", 64'(llen_a), 64'd12);
        step(1, 1, 1, D, 4'h1, 4'h1, 2);
        chk("t4_under", 64'(pulse_a), 64'h20);
        step(1, 1, 1, D, 4'h3, 4'h3, 3);
        chk("t4_min_ok", 64'(pulse_a), 64'h0);

        // stall limit of 4
        for (int i = 1; i <= 6; i++) begin
            step(1, 0, 0, D, 4'hF, 4'hF, 2);
            chk("t5_stall", 64'(pulse_a[6]), (i == 4) ? 64'h1 : 64'h0);
        end
        step(1, 1, 1, D, 4'hF, 4'hF, 2);

        // reset mid-packet with VALID high across release
        step(1, 1, 0, D, 4'hF, 4'hF, 0);
        tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pulse", 64'(pulse_d), 64'h0);
        chk("t6_rst_err",   64'(err_d),   64'h0);
        chk("t6_rst_pkt",   64'(pkt_d),   64'h0);
        chk("t6_rst_beat",  64'(beat_d),  64'h0);
        chk("t6_rst_len",   64'(llen_a),  64'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 1, D, 4'hF, 4'hF, 0);
        chk("t6_rstvalid", 64'(pulse_d), 64'h01);
        chk("t6_lv",       64'(lv_d),    64'h1);
        chk("t6_len",      64'(llen_d),  64'd4);
        chk("t6_pkt",      64'(pkt_d),   64'h1);
        step(0, 0, 0, '0, 4'h0, 4'h0, 0);
        step(0, 0, 0, '0, 4'h0, 4'h0, 0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_stream_monitor.md
# axis_stream_monitor

Synthesizable, passive AXI-Stream protocol monitor and packet-statistics block for one AXI-Stream link, with per-TDEST packet tracking. It taps a link between any master and slave without driving it. Protocol violations are flagged as one-cycle pulses and sticky error bits, so hardware catches the same faults on silicon that the formal bench catches in simulation. Per-channel packet lengths, packet counts and stall limits are tracked, and width, channel count and limits are generalised.

## Interface
Parameters:
- DW, 32 — TDATA width in bits; multiple of 8.
- IDW, 1 — TID width.
- DESTW, 2 — TDEST width; NCHAN = 2**DESTW independent length trackers.
- UW, 1 — TUSER width.
- LGPKT, 16 — per-channel byte-length counter width.
- LGCNT, 32 — packet and beat statistics counter width.
- F_MAX_PACKET, 0 — max bytes per packet; 0 disables the check.
- F_MIN_PACKET, 0 — min bytes per packet; 0 disables the check.
- F_MAX_STALL, 0 — max consecutive VALID && !READY cycles; 0 disables the check.

Ports:
- i_aclk  in  1  clock.
- i_aresetn  in  1  reset; asynchronous, active-low.
- i_tvalid, i_tready, i_tlast  in  1  tapped handshake and last signals.
- i_tdata  in  DW  tapped data.
- i_tstrb, i_tkeep  in  DW/8  tapped byte qualifiers.
- i_tid  in  IDW  tapped ID.
- i_tdest  in  DESTW  tapped destination; selects the tracker.
- i_tuser  in  UW  tapped user sideband.
- i_clear  in  1  clears o_err.
- o_err_pulse  out  7  per-bit error strobe.
- o_err  out  7  sticky errors.
- o_pkt_count  out  LGCNT  completed packets, saturating.
- o_beat_count  out  LGCNT  accepted beats, saturating.
- o_last_valid  out  1  strobe: a packet completed.
- o_last_len  out  LGPKT  byte length of that packet.
- o_last_dest  out  DESTW  TDEST of that packet.

## Operation
- Handshake: a beat is accepted when i_tvalid && i_tready.
- vbytes = popcount(i_tkeep & i_tstrb) when i_tvalid, else 0.
- Error bits (indices live in the package):
  - 0 RSTVALID: i_tvalid high at the first edge after reset release.
  - 1 DROP: i_tvalid falls after a stalled cycle without a handshake.
  - 2 UNSTABLE: any of the following changes after a stalled cycle, while VALID is still high:
    - TSTRB, TKEEP, TLAST, TID, TDEST or TUSER;
    - a TDATA byte whose current TKEEP bit is 1.
  - 3 RESERVED: i_tvalid && |(~i_tkeep & i_tstrb).
  - 4 OVERLEN: an accepted beat where chan_len[dest] + vbytes > F_MAX_PACKET.
  - 5 UNDERLEN: an accepted TLAST beat where chan_len[dest] + vbytes < F_MIN_PACKET.
  - 6 STALL: stall counter reaches F_MAX_STALL. Fires once per stall episode.
- Per-channel length tracking, on an accepted beat with dest = i_tdest:
  - TLAST beat: o_last_len ← chan_len[dest] + vbytes, saturating; o_last_dest ← dest; o_last_valid ← 1; chan_len[dest] ← 0; o_pkt_count++.
  - Other beats: chan_len[dest] ← chan_len[dest] + vbytes, saturating at all-ones.
  - Only the addressed channel's tracker changes, so interleaved TDEST streams are tracked independently.
- Stall counter:
  - Clears when !i_tvalid || i_tready.
  - Otherwise increments, saturating at F_MAX_STALL.
- Sticky register: o_err ← (o_err & ~{7{i_clear}}) | o_err_pulse. A set on the same cycle as i_clear wins.
- Disabled checks (parameter 0) hold their bits at 0.

## Timing
- Every output is registered. A pulse or strobe is asserted for exactly one cycle, in the cycle after the offending or completing edge.
- Reset, asynchronous, clears all of the following to 0:
  - every output, every chan_len, the stall counter;
  - the past-sample registers;
  - the "past valid" flag, which suppresses DROP and UNSTABLE on the first post-reset edge.
- Reset mid-packet discards all partial lengths; no o_last_valid is produced for the discarded packets.
- Length and statistics counters saturate rather than wrap.
- Simultaneous errors: several bits may pulse on the same cycle.

## Structure
- Package axis_mon_pkg:
  - ERR_W = 7;
  - error index constants ERR_RSTVALID … ERR_STALL.
- Sub-module axis_mon_lenctr: one per channel, instantiated with a generate loop. Implements a saturating LGPKT-bit accumulator with clear-on-last, plus the OVERLEN/UNDERLEN compare.
- Popcount and the stability compare stay in the top level.

## Test plan
1. Reset, then a 3-beat packet on dest 1 with TKEEP = TSTRB = 4'hF and no stalls → o_last_valid one cycle after the last beat, o_last_len = 12, o_last_dest = 1, o_pkt_count = 1, o_err = 0.
2. Stall with TKEEP = 4'h3:
   - change TDATA[31:16] → no error;
   - change TDATA[7:0] → o_err_pulse[2] for one cycle and o_err[2] sticky;
   - assert i_clear together with a new pulse → bit stays set.
3. Drop i_tvalid while i_tready = 0 → o_err_pulse[1]. A beat with TKEEP = 0, TSTRB = 1 → o_err_pulse[3].
4. F_MAX_PACKET = 8, interleaved 4-byte beats dest0, dest1, dest0, dest0 → OVERLEN only on the third dest0 beat; dest1 length stays 4.
5. F_MAX_STALL = 4, VALID held with READY low for 6 cycles → exactly one o_err_pulse[6], the cycle after the 4th stall cycle.
6. Assert i_aresetn low mid-packet, then release with i_tvalid high → all outputs 0 during reset; o_err_pulse[0] after release; no o_last_valid for the aborted packet.
